// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter and its baud counter.
// FSM state encodings and the default bit period for the 12 MHz board clock.
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP   = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } uart_state_t;

  localparam int BOARD_CLK_HZ     = 12_000_000;
  localparam int BAUD_RATE        = 115_200;
  localparam int DEF_CLKS_PER_BIT = BOARD_CLK_HZ / BAUD_RATE;

endpackage

// File: rtl/fifo_uart_tx_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// Shared with the receiver, so it holds no knowledge of frame structure.
module baud_tick
  import fifo_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Held off while cleared so a phase never ends during its load cycle.
  assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a fall-through FIFO and sends each word as a start/data/stop UART frame.
// tx is registered from the next-state decode so the line never glitches.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int D_WIDTH      = 8,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               empty,
  input  logic [D_WIDTH-1:0] r_data,
  output logic               rd,
  output logic               tx,
  output logic               busy,
  output logic               done
);

  localparam int BIT_W = (D_WIDTH > 1) ? $clog2(D_WIDTH) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(D_WIDTH - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  uart_state_t        state, state_nxt;
  logic [BIT_W-1:0]   bit_idx, bit_nxt;
  logic               stop_cnt, stop_nxt;
  logic [D_WIDTH-1:0] shreg, shreg_nxt;
  logic               tx_nxt;
  logic               tick;
  logic               baud_clear;

  // The bit period restarts whenever a frame is about to begin.
  assign baud_clear = (state == IDLE) || (state == POP);

  baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (baud_clear),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
      tx       <= 1'b1;
    end else begin
      state    <= state_nxt;
      bit_idx  <= bit_nxt;
      stop_cnt <= stop_nxt;
      tx       <= tx_nxt;
    end
  end

  // Payload shifter carries no reset; it is reloaded in POP before any use.
  always_ff @(posedge clk) begin
    shreg <= shreg_nxt;
  end

  always_comb begin
    state_nxt = state;
    bit_nxt   = bit_idx;
    stop_nxt  = stop_cnt;
    shreg_nxt = shreg;
    unique case (state)
      IDLE: begin
        if (en && !empty) state_nxt = POP;
      end
      POP: begin
        shreg_nxt = r_data;
        bit_nxt   = '0;
        stop_nxt  = 1'b0;
        state_nxt = START;
      end
      START: begin
        if (tick) state_nxt = DATA;
      end
      DATA: begin
        if (tick) begin
          shreg_nxt = shreg >> 1;
          if (bit_idx == BIT_LAST) begin
            stop_nxt  = 1'b0;
            state_nxt = STOP;
          end else begin
            bit_nxt = bit_idx + BIT_W'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (stop_cnt == STOP_LAST) begin
            state_nxt = (en && !empty) ? POP : IDLE;
          end else begin
            stop_nxt = stop_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    unique case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shreg_nxt[0];
      default: tx_nxt = 1'b1;
    endcase
  end

  always_comb begin
    rd   = (state == POP);
    busy = (state != IDLE);
    done = (state == STOP) && tick && (stop_cnt == STOP_LAST);
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a small behavioural fall-through FIFO in front.
// A line receiver decodes frames; each scenario task checks its own expectations.
module tb_fifo_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic       empty;
  logic [7:0] r_data;
  logic       rd, tx, busy, done;

  int total = 0;
  int bad   = 0;

  // behavioural FIFO, depth 8
  logic [7:0] mem [8];
  logic [2:0] wp = 3'd0, rp = 3'd0;
  logic [3:0] fcnt = 4'd0;
  logic       wr = 1'b0, fclr = 1'b0;
  logic [7:0] w_data = 8'h00;
  logic       do_w, do_r;
  int         rd_cnt = 0;
  int         rd_empty_err = 0;

  assign empty  = (fcnt == 4'd0);
  assign r_data = mem[rp];
  assign do_w   = wr && (fcnt != 4'd8);
  assign do_r   = rd && (fcnt != 4'd0);

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd) rd_cnt <= rd_cnt + 1;
    if (rd && fcnt == 4'd0) rd_empty_err <= rd_empty_err + 1;
    if (fclr) begin
      wp <= 3'd0; rp <= 3'd0; fcnt <= 4'd0;
    end else begin
      if (do_w) begin
        mem[wp] <= w_data;
        wp <= wp + 3'd1;
      end
      if (do_r) rp <= rp + 3'd1;
      if (do_w && !do_r) fcnt <= fcnt + 4'd1;
      else if (!do_w && do_r) fcnt <= fcnt - 4'd1;
    end
  end

  fifo_uart_tx #(
    .D_WIDTH      (8),
    .CLKS_PER_BIT (4),
    .STOP_BITS    (1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .empty  (empty),
    .r_data (r_data),
    .rd     (rd),
    .tx     (tx),
    .busy   (busy),
    .done   (done)
  );

  task automatic push(input logic [7:0] b);
    @(negedge clk); wr = 1'b1; w_data = b;
    @(negedge clk); wr = 1'b0;
  endtask

  task automatic flush();
    @(negedge clk); fclr = 1'b1;
    @(negedge clk); fclr = 1'b0;
  endtask

  // Waits (bounded) for a start bit, then samples each bit in its third cycle.
  // waited = negedges until tx was first seen low.
  task automatic recv_frame(output logic [7:0] data, output int waited,
                            output bit frame_ok, output bit done_ok);
    data = 8'h00; waited = 0; frame_ok = 1'b1; done_ok = 1'b0;
    do begin
      @(negedge clk); waited++;
    end while (tx !== 1'b0 && waited < 200);
    if (tx !== 1'b0) begin
      frame_ok = 1'b0;
      return;
    end
    repeat (2) @(negedge clk);
    if (tx !== 1'b0) frame_ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (4) @(negedge clk);
      data[i] = tx;
    end
    repeat (4) @(negedge clk);
    if (tx !== 1'b1 || done !== 1'b0) frame_ok = 1'b0;
    @(negedge clk);
    if (tx !== 1'b1) frame_ok = 1'b0;
    done_ok = (done === 1'b1);
  endtask

  task automatic test_reset();
    logic [7:0] d; int w; bit fok, dok;
    flush();
    push(8'h55);
    #1;
    total++;
    if (tx !== 1'b1 || rd !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold: tx=%b rd=%b busy=%b done=%b, required tx=1 rd=0 busy=0 done=0",
               tx, rd, busy, done);
    end
    @(negedge clk); rst = 1'b1;
    repeat (12) @(negedge clk);
    total++;
    if (rd_cnt !== 0 || tx !== 1'b1 || busy !== 1'b0 || empty !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: rd_cnt=%0d tx=%b busy=%b empty=%b, required 0 1 0 0",
               rd_cnt, tx, busy, empty);
    end
  endtask

  task automatic test_single();
    logic [7:0] d; int w; bit fok, dok; int base;
    flush();
    push(8'hA5);
    base = rd_cnt;
    @(negedge clk); en = 1'b1;
    @(negedge clk);
    total++;
    if (rd !== 1'b1 || tx !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_pop: rd=%b tx=%b busy=%b, required 1 1 1", rd, tx, busy);
    end
    recv_frame(d, w, fok, dok);
    total++;
    if (w !== 1) begin
      bad++;
      $display("FAIL single_latency: start after %0d more edges, required 1 (2 from en)", w);
    end
    total++;
    if (d !== 8'hA5 || !fok || !dok) begin
      bad++;
      $display("FAIL single_frame: data=%h framing=%0d done=%0d, required a5 1 1", d, fok, dok);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || empty !== 1'b1 || rd_cnt - base !== 1 || done !== 1'b0) begin
      bad++;
      $display("FAIL single_end: busy=%b empty=%b pops=%0d done=%b, required 0 1 1 0",
               busy, empty, rd_cnt - base, done);
    end
    en = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] d; int w; bit fok, dok; int base;
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h55; exp_b[1] = 8'h01; exp_b[2] = 8'h02;
    flush();
    for (int i = 0; i < 3; i++) push(exp_b[i]);
    base = rd_cnt;
    @(negedge clk); en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      recv_frame(d, w, fok, dok);
      total++;
      if (d !== exp_b[i] || w !== 2 || !fok || !dok) begin
        bad++;
        $display("FAIL b2b_frame%0d: data=%h gap_edges=%0d framing=%0d done=%0d, required %h 2 1 1",
                 i, d, w, fok, dok, exp_b[i]);
      end
    end
    @(negedge clk);
    total++;
    if (rd_cnt - base !== 3 || busy !== 1'b0 || empty !== 1'b1) begin
      bad++;
      $display("FAIL b2b_end: pops=%0d busy=%b empty=%b, required 3 0 1", rd_cnt - base, busy, empty);
    end
    en = 1'b0;
  endtask

  task automatic test_en_drop();
    logic [7:0] d; int w; bit fok, dok; int base;
    flush();
    push(8'h3C);
    push(8'hC3);
    base = rd_cnt;
    @(negedge clk); en = 1'b1;
    fork
      recv_frame(d, w, fok, dok);
      begin
        repeat (20) @(negedge clk);
        en = 1'b0;
      end
    join
    total++;
    if (d !== 8'h3C || !fok || !dok) begin
      bad++;
      $display("FAIL endrop_frame1: data=%h framing=%0d done=%0d, required 3c 1 1", d, fok, dok);
    end
    repeat (10) @(negedge clk);
    total++;
    if (busy !== 1'b0 || empty !== 1'b0 || rd_cnt - base !== 1 || tx !== 1'b1) begin
      bad++;
      $display("FAIL endrop_idle: busy=%b empty=%b pops=%0d tx=%b, required 0 0 1 1",
               busy, empty, rd_cnt - base, tx);
    end
    en = 1'b1;
    recv_frame(d, w, fok, dok);
    total++;
    if (d !== 8'hC3 || w !== 2 || !fok || !dok) begin
      bad++;
      $display("FAIL endrop_frame2: data=%h wait=%0d framing=%0d done=%0d, required c3 2 1 1",
               d, w, fok, dok);
    end
    @(negedge clk);
    total++;
    if (empty !== 1'b1 || rd_cnt - base !== 2) begin
      bad++;
      $display("FAIL endrop_end: empty=%b pops=%0d, required 1 2", empty, rd_cnt - base);
    end
    en = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d; int w; bit fok, dok; int base; int n;
    flush();
    push(8'hF0);
    push(8'h81);
    base = rd_cnt;
    @(negedge clk); en = 1'b1;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (tx !== 1'b0 && n < 200);
    total++;
    if (tx !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_start: tx=%b after %0d cycles, required 0", tx, n);
    end
    repeat (17) @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (tx !== 1'b1 || busy !== 1'b0 || rd !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_abort: tx=%b busy=%b rd=%b, required 1 0 0", tx, busy, rd);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    recv_frame(d, w, fok, dok);
    total++;
    if (d !== 8'h81 || w !== 2 || !fok || !dok) begin
      bad++;
      $display("FAIL rstmid_next: data=%h wait=%0d framing=%0d done=%0d, required 81 2 1 1",
               d, w, fok, dok);
    end
    @(negedge clk);
    total++;
    if (rd_cnt - base !== 2 || empty !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_pops: pops=%0d empty=%b busy=%b, required 2 1 0", rd_cnt - base, empty, busy);
    end
    en = 1'b0;
  endtask

  task automatic test_full_drain();
    logic [7:0] d; int w; bit fok, dok; int base;
    flush();
    for (int i = 0; i < 8; i++) push(8'(i));
    total++;
    if (fcnt !== 4'd8) begin
      bad++;
      $display("FAIL drain_fill: level=%0d, required 8", fcnt);
    end
    base = rd_cnt;
    @(negedge clk); en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      recv_frame(d, w, fok, dok);
      total++;
      if (d !== 8'(i) || w !== 2 || !fok || !dok) begin
        bad++;
        $display("FAIL drain_frame%0d: data=%h wait=%0d framing=%0d done=%0d, required %h 2 1 1",
                 i, d, w, fok, dok, 8'(i));
      end
    end
    repeat (20) @(negedge clk);
    total++;
    if (rd_cnt - base !== 8 || empty !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin
      bad++;
      $display("FAIL drain_end: pops=%0d empty=%b busy=%b tx=%b, required 8 1 0 1",
               rd_cnt - base, empty, busy, tx);
    end
    total++;
    if (rd_empty_err !== 0) begin
      bad++;
      $display("FAIL rd_while_empty: count=%0d, required 0", rd_empty_err);
    end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_en_drop();
    test_reset_mid_frame();
    test_full_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
